// File: rtl/cordic_ci_ctrl.sv
// Custom-instruction front end for the free-running CORDIC pipeline: issues theta, tags samples, collects results.
// Latency: EVAL PIPE_LAT+2 cycles; PUSH/STAT/ready POP 1 cycle; POP on empty FIFO waits for the next batch exit.
// Backpressure: PUSH stalls (no done) while queued plus in-flight batch samples fill DEPTH; done waits for clk_en.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   clk_en, start   - CI enable and request strobe (start honoured only with clk_en in IDLE)
//   n, dataa        - opcode (0 EVAL, 1 PUSH, 2 POP, 3 STAT) and theta operand
//   result, done    - CI result and one-cycle completion pulse
//   theta_out       - registered theta to the pipeline, 0 when nothing is issued
//   pipe_result     - pipeline output, valid PIPE_LAT cycles after the matching theta_out
module cordic_ci_ctrl #(
    parameter int PIPE_LAT = 46,
    parameter int DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic [31:0] theta_out,
    input  logic [31:0] pipe_result
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];
    localparam logic [31:0] QNAN    = 32'h7fc00000;

    localparam logic [1:0] OP_EVAL = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_STAT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EVAL,
        WAIT_SPACE,
        WAIT_POP
    } state_t;

    state_t state_q, state_d;

    // Tag index k travels alongside the sample issued k cycles before the
    // current theta_out, so index PIPE_LAT lines up with pipe_result.
    logic [PIPE_LAT:0] tag_vld_q;
    logic [PIPE_LAT:0] tag_bat_q;

    logic [CW-1:0] inflight_q;
    logic [CW-1:0] fifo_count_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   theta_hold_q;
    logic          done_q;

    logic          exit_vld;
    logic          fifo_push;
    logic          eval_exit;
    logic          fifo_empty;
    logic          space;
    logic [31:0]   fifo_head;
    logic [31:0]   stat_val;

    logic          issue;
    logic          issue_batch;
    logic [31:0]   issue_theta;
    logic          cmpl;
    logic [31:0]   cmpl_val;
    logic          fifo_pop;
    logic          latch_theta;

    assign exit_vld   = tag_vld_q[PIPE_LAT];
    assign fifo_push  = exit_vld & tag_bat_q[PIPE_LAT];
    assign eval_exit  = exit_vld & ~tag_bat_q[PIPE_LAT];
    assign fifo_empty = (fifo_count_q == '0);
    assign fifo_head  = mem[rd_ptr_q];
    // A batch exit moves a sample from in-flight to queued, so only a pop frees space.
    assign space      = ({1'b0, fifo_count_q} + {1'b0, inflight_q}) < DEPTH_W;
    assign stat_val   = {{(16-CW){1'b0}}, inflight_q, {(16-CW){1'b0}}, fifo_count_q};

    // done stays pending through clk_en-low cycles and shows on the first enabled one.
    assign done = done_q & clk_en;

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        issue_batch = 1'b0;
        issue_theta = dataa;
        cmpl        = 1'b0;
        cmpl_val    = result;
        fifo_pop    = 1'b0;
        latch_theta = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && clk_en) begin
                    case (n)
                        OP_EVAL: begin
                            issue   = 1'b1;
                            state_d = WAIT_EVAL;
                        end
                        OP_PUSH: begin
                            if (space) begin
                                issue       = 1'b1;
                                issue_batch = 1'b1;
                                cmpl        = 1'b1;
                                cmpl_val    = '0;
                            end else begin
                                latch_theta = 1'b1;
                                state_d     = WAIT_SPACE;
                            end
                        end
                        OP_POP: begin
                            if (!fifo_empty) begin
                                cmpl     = 1'b1;
                                cmpl_val = fifo_head;
                                fifo_pop = 1'b1;
                            end else if (inflight_q != '0) begin
                                state_d = WAIT_POP;
                            end else begin
                                cmpl     = 1'b1;
                                cmpl_val = QNAN;
                            end
                        end
                        default: begin
                            cmpl     = 1'b1;
                            cmpl_val = stat_val;
                        end
                    endcase
                end
            end
            WAIT_EVAL: begin
                if (eval_exit) begin
                    cmpl     = 1'b1;
                    cmpl_val = pipe_result;
                    state_d  = IDLE;
                end
            end
            WAIT_SPACE: begin
                if (space) begin
                    issue       = 1'b1;
                    issue_batch = 1'b1;
                    issue_theta = theta_hold_q;
                    cmpl        = 1'b1;
                    cmpl_val    = '0;
                    state_d     = IDLE;
                end
            end
            WAIT_POP: begin
                if (!fifo_empty) begin
                    cmpl     = 1'b1;
                    cmpl_val = fifo_head;
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tag_vld_q    <= '0;
            tag_bat_q    <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            theta_hold_q <= '0;
            theta_out    <= '0;
            result       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_vld_q <= {tag_vld_q[PIPE_LAT-1:0], issue};
            tag_bat_q <= {tag_bat_q[PIPE_LAT-1:0], issue & issue_batch};
            theta_out <= issue ? issue_theta : '0;

            if (latch_theta) begin
                theta_hold_q <= dataa;
            end
            if (cmpl) begin
                result <= cmpl_val;
            end
            done_q <= cmpl | (done_q & ~clk_en);

            if ((issue & issue_batch) && !fifo_push) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (!(issue & issue_batch) && fifo_push) begin
                inflight_q <= inflight_q - 1'b1;
            end

            if (fifo_push && !fifo_pop) begin
                fifo_count_q <= fifo_count_q + 1'b1;
            end else if (!fifo_push && fifo_pop) begin
                fifo_count_q <= fifo_count_q - 1'b1;
            end
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr_q] <= pipe_result;
        end
    end

endmodule
